uart_rx_fsm: RTL and testbench

Control FSM for the UART receiver. It enables the edge/bit counter and sequences the start-glitch, data-deserialise, parity and stop checks using the counter's edge_count and bit_count. It raises a one-cycle data_valid when a frame completes with no error. It sits between the serial input and the RX datapath blocks: edge/bit counter, data sampler, deserializer, parity, start and stop checkers.

---
 rtl/uart_rx_fsm.sv | 133 +++++++++++++
 tb/tb_uart_rx_fsm.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm -- control sequencer for the UART receiver.
//
// Walks a frame through START -> DATA -> (PARITY) -> STOP using the edge/bit
// counter, fires one-cycle check/shift strobes at the end of each bit and
// raises a registered one-cycle data_valid when a frame completes cleanly.
//
// Ports:
//   clk, rst        oversampling clock, async active-low reset
//   rx_in           serial line (idle high), only looked at in IDLE
//   par_en          parity bit present; captured at frame start
//   prescale        oversampling ratio (edges per bit)
//   edge_count      edge index within the current bit (from counter)
//   bit_count       bit index within the frame, 0 = start (from counter)
//   strt_glitch     start checker result, sampled on strt_chk_en
//   par_err         parity checker result, sampled on par_chk_en
//   stp_err         stop checker result, sampled on stp_chk_en
//   cnt_enable      counter enable; low clears the counter
//   samp_en         data sampler enable
//   deser_en        deserializer shift strobe, once per data bit
//   strt_chk_en     start check strobe
//   par_chk_en      parity check strobe
//   stp_chk_en      stop check strobe
//   data_valid      one-cycle frame-good pulse, first IDLE cycle after STOP
//   busy            frame in progress
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic                  par_en,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [PRESCALE_W-1:0] edge_count,
  input  logic [3:0]            bit_count,
  input  logic                  strt_glitch,
  input  logic                  par_err,
  input  logic                  stp_err,
  output logic                  cnt_enable,
  output logic                  samp_en,
  output logic                  deser_en,
  output logic                  strt_chk_en,
  output logic                  par_chk_en,
  output logic                  stp_chk_en,
  output logic                  data_valid,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [3:0] LAST_DATA = 4'(DATA_WIDTH);
  localparam logic [3:0] BIT_MAX   = 4'(DATA_WIDTH + 2);

  state_t state, state_nxt;
  logic   par_en_q;
  logic   bit_end;
  logic   in_frame;
  logic   cnt_fault;
  logic   frame_start;
  logic   frame_good;

  assign bit_end     = (edge_count == prescale);
  assign in_frame    = (state != IDLE);
  // In the first IDLE cycle the counter can still hold the previous frame's
  // final count (it clears on the following edge), so an out-of-range
  // bit_count is only treated as a fault while a frame is in progress.
  assign cnt_fault   = in_frame && (bit_count > BIT_MAX);
  assign frame_start = (state == IDLE) && !rx_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      par_en_q   <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      data_valid <= frame_good;
      if (frame_start) par_en_q <= par_en;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_enable  = in_frame;
    samp_en     = in_frame;
    busy        = in_frame;
    strt_chk_en = 1'b0;
    deser_en    = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    frame_good  = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_in) state_nxt = START;
      end
      START: begin
        strt_chk_en = bit_end;
        if (bit_end) state_nxt = strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        deser_en = bit_end;
        if (bit_end && bit_count == LAST_DATA)
          state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        par_chk_en = bit_end;
        if (bit_end) state_nxt = par_err ? IDLE : STOP;
      end
      STOP: begin
        stp_chk_en = bit_end;
        if (bit_end) begin
          state_nxt  = IDLE;
          frame_good = !stp_err;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A broken counter aborts the frame silently.
    if (cnt_fault) begin
      state_nxt  = IDLE;
      frame_good = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: models the edge/bit counter, drives serial frames
// and checker results, and scores per-frame strobe counts and data_valid
// against expectations queued when each frame is launched.
module tb_uart_rx_fsm;

  localparam int DW = 8;
  localparam int PW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_in = 1'b1;
  logic          par_en = 1'b0;
  logic [PW-1:0] prescale = 5'd8;
  logic [PW-1:0] edge_count;
  logic [3:0]    bit_count;
  logic          strt_glitch = 1'b0;
  logic          par_err = 1'b0;
  logic          stp_err = 1'b0;
  logic          cnt_enable, samp_en, deser_en, strt_chk_en;
  logic          par_chk_en, stp_chk_en, data_valid, busy;

  always #5 clk = ~clk;

  uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .par_en(par_en),
    .prescale(prescale), .edge_count(edge_count), .bit_count(bit_count),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .cnt_enable(cnt_enable), .samp_en(samp_en), .deser_en(deser_en),
    .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
    .stp_chk_en(stp_chk_en), .data_valid(data_valid), .busy(busy)
  );

  typedef struct {
    int strt, deser, par, stp, dv;
  } exp_t;

  typedef struct {
    logic [PW-1:0] ps;
    bit            pe;
    logic [7:0]    data;
    bit            glitch, perr, serr;
    int            gap, abort_bit, fault_bit;
    exp_t          e;
  } vec_t;

  int   total = 0;
  int   bad = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // Counter model: cleared while disabled, edges 1..prescale per bit after
  // the start bit (which also covers edge 0).
  logic [PW-1:0] ec_m;
  logic [3:0]    bc_m;
  logic          force_bc = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ec_m <= '0;
      bc_m <= '0;
    end else if (!cnt_enable) begin
      ec_m <= '0;
      bc_m <= '0;
    end else if (ec_m == prescale) begin
      ec_m <= 5'd1;
      bc_m <= bc_m + 4'd1;
    end else begin
      ec_m <= ec_m + 5'd1;
    end
  end

  assign edge_count = ec_m;
  assign bit_count  = force_bc ? 4'd12 : bc_m;

  // Monitor: counts strobes per frame, scores on the busy falling edge.
  int   c_strt = 0, c_deser = 0, c_par = 0, c_stp = 0;
  int   idle_run = 0, last_gap = 0;
  bit   prev_busy = 1'b0;
  exp_t mon_e;

  initial forever begin
    @(negedge clk);
    if (prev_busy && !busy) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL frame_end: unexpected frame end with nothing queued");
      end else begin
        mon_e = exp_q.pop_front();
        check("strt_chk_pulses", c_strt, mon_e.strt);
        check("deser_pulses", c_deser, mon_e.deser);
        check("par_chk_pulses", c_par, mon_e.par);
        check("stp_chk_pulses", c_stp, mon_e.stp);
        check("data_valid", int'(data_valid), mon_e.dv);
        check("cnt_en_at_end", int'(cnt_enable), 0);
      end
      c_strt = 0; c_deser = 0; c_par = 0; c_stp = 0;
    end else begin
      check("stray_dv", int'(data_valid), 0);
    end
    if (strt_chk_en) c_strt++;
    if (deser_en)    c_deser++;
    if (par_chk_en)  c_par++;
    if (stp_chk_en)  c_stp++;
    if (!cnt_enable) idle_run++;
    else begin
      if (idle_run > 0) last_gap = idle_run;
      idle_run = 0;
    end
    prev_busy = busy;
  end

  function automatic vec_t mk(input logic [PW-1:0] ps, input bit pe,
                              input logic [7:0] d, input bit g, input bit pr,
                              input bit sr, input int gap, input int ab,
                              input int fb, input int es, input int ed,
                              input int ep, input int et, input int ev);
    vec_t v;
    v.ps = ps; v.pe = pe; v.data = d; v.glitch = g; v.perr = pr; v.serr = sr;
    v.gap = gap; v.abort_bit = ab; v.fault_bit = fb;
    v.e.strt = es; v.e.deser = ed; v.e.par = ep; v.e.stp = et; v.e.dv = ev;
    return v;
  endfunction

  // Must be called at a negedge; returns at the negedge of the first IDLE
  // cycle, so back-to-back calls give zero idle bits.
  task automatic drive_frame(input vec_t v);
    logic fb[16];
    int   stop_idx;
    bit   started, done, be;
    for (int i = 0; i < 16; i++) fb[i] = 1'b1;
    fb[0] = 1'b0;
    for (int i = 0; i < DW; i++) fb[i+1] = v.data[i];
    if (v.pe) fb[DW+1] = ^v.data;
    stop_idx = DW + 1 + (v.pe ? 1 : 0);
    exp_q.push_back(v.e);
    prescale = v.ps;
    par_en   = v.pe;
    rx_in    = 1'b0;
    started  = 1'b0;
    done     = 1'b0;
    for (int n = 0; n < 3000 && !done; n++) begin
      @(negedge clk);
      if (!busy) begin
        if (!started) begin
          total++; bad++;
          $display("FAIL frame_start: busy=0 want 1");
        end
        rx_in    = 1'b1;
        force_bc = 1'b0;
        done     = 1'b1;
      end else begin
        started  = 1'b1;
        par_en   = ~v.pe;  // must be ignored mid-frame
        rx_in    = v.glitch ? (n < 1 ? 1'b0 : 1'b1) : fb[bc_m];
        be       = (ec_m == v.ps);
        strt_glitch = (be && bc_m == 4'd0) ? v.glitch : 1'($urandom);
        par_err  = (be && int'(bc_m) == DW + 1) ? v.perr : 1'($urandom);
        stp_err  = (be && int'(bc_m) == stop_idx) ? v.serr : 1'($urandom);
        force_bc = (int'(bc_m) == v.fault_bit && ec_m == 5'd2);
        if (int'(bc_m) == v.abort_bit && ec_m == 5'd2) begin
          #2 rst = 1'b0;
          #1;
          check("abort_cnt_en", int'(cnt_enable), 0);
          check("abort_busy", int'(busy), 0);
          check("abort_dv", int'(data_valid), 0);
        end
      end
    end
    if (!done) begin
      total++; bad++;
      $display("FAIL frame_timeout: busy still %0d after 3000 cycles", busy);
      force_bc = 1'b0;
      rx_in    = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[8];

  initial begin
    //           ps  pe data   g  pe se gap abt flt  strt des par stp dv
    tbl[0] = mk(8,  0, 8'hA5, 0, 0, 0, 2, -1, -1, 1, 8, 0, 1, 1);
    tbl[1] = mk(16, 1, 8'h3C, 0, 0, 0, 2, -1, -1, 1, 8, 1, 1, 1);
    tbl[2] = mk(16, 1, 8'h3C, 0, 1, 0, 2, -1, -1, 1, 8, 1, 0, 0);
    tbl[3] = mk(8,  0, 8'hA5, 1, 0, 0, 2, -1, -1, 1, 0, 0, 0, 0);
    tbl[4] = mk(8,  0, 8'hC3, 0, 0, 1, 2, -1, -1, 1, 8, 0, 1, 0);
    tbl[5] = mk(8,  0, 8'h5A, 0, 0, 0, 1, -1, -1, 1, 8, 0, 1, 1);
    tbl[6] = mk(31, 1, 8'h01, 0, 0, 0, 2, -1, -1, 1, 8, 1, 1, 1);
    tbl[7] = mk(8,  0, 8'hFF, 0, 0, 0, 2, -1,  3, 1, 2, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_cnt_en", int'(cnt_enable), 0);
    check("rst_samp_en", int'(samp_en), 0);
    check("rst_dv", int'(data_valid), 0);
    check("rst_strt_chk", int'(strt_chk_en), 0);
    check("rst_deser", int'(deser_en), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of data bit 4: three shifts already done.
    drive_frame(mk(8, 0, 8'hA5, 0, 0, 0, 0, 4, -1, 1, 3, 0, 0, 0));
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      repeat (tbl[i].gap) @(negedge clk);
      drive_frame(tbl[i]);
    end

    // Back-to-back frames with no idle bits between them.
    repeat (4) @(negedge clk);
    drive_frame(mk(8, 0, 8'h55, 0, 0, 0, 0, -1, -1, 1, 8, 0, 1, 1));
    drive_frame(mk(8, 0, 8'hAA, 0, 0, 0, 0, -1, -1, 1, 8, 0, 1, 1));
    check("b2b_cnt_en_gap", last_gap, 1);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
